// File: rtl/template_capture_ram.sv
// Captures one frame of the down-scaled pixel stream into a RAM behind a ROM-compatible read port.
// Read data is registered one cycle after the address. The stream has no backpressure: pixels outside ARM/FILL are dropped.
module template_capture_ram #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int TEMPLATE_LEN = 2048
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_capture_start,
  input  logic                  i_capture_abort,
  input  logic                  i_pix_valid,
  input  logic                  i_pix_sof,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_tmpl_valid,
  output logic [ADDR_WIDTH:0]   o_wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_FILL, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(TEMPLATE_LEN - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_wr_count;
  logic [ADDR_WIDTH:0]   w_wr_count_nxt;
  logic                  r_tmpl_valid;
  logic                  w_tmpl_valid_nxt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wr_count   <= '0;
      r_tmpl_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_count   <= w_wr_count_nxt;
      r_tmpl_valid <= w_tmpl_valid_nxt;
    end
  end

  // Abort is tested before any write so an aborting cycle never touches the RAM.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_count_nxt   = r_wr_count;
    w_tmpl_valid_nxt = r_tmpl_valid;
    w_we             = 1'b0;
    w_waddr          = r_wr_count[ADDR_WIDTH-1:0];
    case (r_state)
      S_IDLE: begin
        if (i_capture_start) begin
          w_state_nxt      = S_ARM;
          w_wr_count_nxt   = '0;
          w_tmpl_valid_nxt = 1'b0;
        end
      end
      S_ARM: begin
        if (i_capture_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_pix_valid && i_pix_sof) begin
          w_we           = 1'b1;
          w_waddr        = '0;
          w_wr_count_nxt = CNT_ONE;
          w_state_nxt    = (TEMPLATE_LEN == 1) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (i_capture_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_pix_valid) begin
          w_we           = 1'b1;
          w_wr_count_nxt = r_wr_count + CNT_ONE;
          if (r_wr_count == CNT_LAST) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_tmpl_valid_nxt = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= i_pix_data;
    end
  end

  // Read-during-write to the same address returns the pre-write word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_addr];
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_busy       = (r_state == S_ARM) || (r_state == S_FILL);
  assign o_done       = (r_state == S_DONE);
  assign o_tmpl_valid = r_tmpl_valid;
  assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_template_capture_ram.sv
// Scoreboard bench for template_capture_ram: a capture-level model predicts every post-edge output.
module tb_template_capture_ram;
  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int LEN = 2048;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_FILL = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_start = 1'b0;
  logic          cap_abort = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          tmpl_valid;
  logic [AW:0]   wr_count;

  template_capture_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TEMPLATE_LEN(LEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_capture_start(cap_start), .i_capture_abort(cap_abort),
    .i_pix_valid(pix_valid), .i_pix_sof(pix_sof), .i_pix_data(pix_data), .i_addr(addr),
    .o_rd_data(rd_data), .o_busy(busy), .o_done(done), .o_tmpl_valid(tmpl_valid),
    .o_wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd_chk;
    logic [DW-1:0] rd;
    bit            busy;
    bit            done;
    bit            tv;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t          q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            n_done = 0;
  logic [DW-1:0] mem_m [LEN];
  bit            known [LEN];
  int            m_phase = M_IDLE;
  int            m_cnt   = 0;
  bit            m_tv    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) n_done++;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rd_chk) check("rd_data", 32'(rd_data), 32'(e.rd));
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
      check("tmpl_valid", 32'(tmpl_valid), 32'(e.tv));
      check("wr_count", 32'(wr_count), 32'(e.cnt));
    end
  end

  function automatic logic [AW-1:0] rnd_a();
    return AW'($urandom_range(0, LEN - 1));
  endfunction

  // One clock of stimulus; the model predicts what the outputs show after the coming edge.
  task automatic tick(input bit st, input bit ab, input bit pv, input bit sof,
                      input logic [DW-1:0] pd, input logic [AW-1:0] a);
    exp_t e;
    cap_start = st; cap_abort = ab; pix_valid = pv; pix_sof = sof; pix_data = pd; addr = a;
    e.rd_chk = known[a];
    e.rd     = mem_m[a];
    if (m_phase == M_IDLE) begin
      if (st) begin m_phase = M_ARM; m_cnt = 0; m_tv = 1'b0; end
    end else if (m_phase == M_DONE) begin
      m_tv = 1'b1; m_phase = M_IDLE;
    end else if (ab) begin
      m_phase = M_IDLE;
    end else if (pv && (m_phase == M_FILL || sof)) begin
      mem_m[m_cnt] = pd;
      known[m_cnt] = 1'b1;
      m_cnt++;
      m_phase = (m_cnt == LEN) ? M_DONE : M_FILL;
    end
    e.busy = (m_phase == M_ARM) || (m_phase == M_FILL);
    e.done = (m_phase == M_DONE);
    e.tv   = m_tv;
    e.cnt  = (AW+1)'(m_cnt);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, DW'($urandom), rnd_a());
  endtask

  task automatic pix(input logic [DW-1:0] d, input bit sof, input logic [AW-1:0] a);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) tick(0, 0, 0, 1'($urandom), DW'($urandom), rnd_a());
    end
    tick(0, 0, 1, sof, d, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_tv", 32'(tmpl_valid), 0);
    check("reset_cnt", 32'(wr_count), 0);
    check("reset_rd", 32'(rd_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Arm filtering: only a sof pixel starts the capture.
    tick(1, 0, 0, 0, 8'h00, rnd_a());
    repeat (5) tick(0, 0, 1, 0, 8'hFF, rnd_a());
    tick(0, 0, 1, 1, 8'h11, rnd_a());
    check("arm_cnt", 32'(wr_count), 1);
    tick(0, 1, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 0, 8'h00, 0);
    check("arm_ram0", 32'(rd_data), 32'h11);

    // Full capture with random gaps, pixel value = address.
    n_done = 0;
    tick(1, 0, 0, 0, 8'h00, rnd_a());
    for (int i = 0; i < LEN; i++) pix(DW'(i), i == 0, rnd_a());
    check("full_done_pulse", 32'(done), 1);
    tick(0, 0, 0, 0, 8'h00, 11'h123);
    check("full_rd_123", 32'(rd_data), 32'h23);
    check("full_tv", 32'(tmpl_valid), 1);
    check("full_ndone", 32'(n_done), 1);

    // Read-during-write at address 7.
    tick(1, 0, 0, 0, 8'h00, rnd_a());
    for (int i = 0; i < 8; i++) tick(0, 0, 1, i == 0, (i == 7) ? 8'hAA : DW'(i), (i == 7) ? 11'd7 : rnd_a());
    check("rdw_old", 32'(rd_data), 32'h07);
    tick(0, 0, 0, 0, 8'h00, 11'd7);
    check("rdw_new", 32'(rd_data), 32'hAA);
    tick(0, 1, 0, 0, 8'h00, rnd_a());

    // Abort after 100 words; the pixel on the abort cycle is not written.
    tick(1, 0, 0, 0, 8'h00, rnd_a());
    for (int i = 0; i < 100; i++) pix(DW'(i + 1), i == 0, rnd_a());
    tick(0, 1, 1, 0, 8'hEE, 11'd100);
    tick(0, 0, 0, 0, 8'h00, 11'd100);
    check("abort_rd100", 32'(rd_data), 32'd100);
    check("abort_cnt", 32'(wr_count), 100);
    check("abort_tv", 32'(tmpl_valid), 0);
    check("abort_busy", 32'(busy), 0);

    // Start and sof during FILL are ignored.
    n_done = 0;
    tick(1, 0, 0, 0, 8'h00, rnd_a());
    for (int i = 0; i < LEN; i++) begin
      if (i == 300) tick(1, 0, 0, 0, 8'h00, rnd_a());
      pix(DW'(i * 3), (i == 0) || (i == 500), rnd_a());
    end
    idle(4);
    check("ign_ndone", 32'(n_done), 1);
    check("ign_tv", 32'(tmpl_valid), 1);

    // Asynchronous reset mid-FILL; partial data stays in RAM.
    tick(1, 0, 0, 0, 8'h00, rnd_a());
    for (int i = 0; i < 50; i++) pix(DW'(i ^ 8'h5A), i == 0, rnd_a());
    cap_start = 0; cap_abort = 0; pix_valid = 0; pix_sof = 0;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_tv", 32'(tmpl_valid), 0);
    check("rst_cnt", 32'(wr_count), 0);
    check("rst_rd", 32'(rd_data), 0);
    q.delete();
    m_phase = M_IDLE; m_cnt = 0; m_tv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick(0, 0, 0, 0, 8'h00, 11'd25);
    check("rst_keep_ram", 32'(rd_data), 32'(8'(25 ^ 8'h5A)));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
